// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 5-stage RV32 pipeline. It combines
// three hazard sources: load-use in ID, mispredict redirects resolved in EX,
// and multi-cycle EX operations. From these it drives the hold and invalidate
// controls of the PC, IF/ID, ID/EX and EX/MEM registers. It also keeps
// saturating stall and flush performance counters.
//
// Ports
//   i_clk, i_reset_n          clock, synchronous active-low reset
//   i_id_rs1/rs2, use_rs1/2   ID-stage source register fields
//   i_ex_valid/memread/rd     EX-stage load descriptor
//   i_ex_mispredict/target    EX-stage branch resolution
//   i_ex_mc_start/mc_done     multi-cycle unit handshake
//   i_cnt_clr                 clear counters and sticky timeout flag
//   o_*_stall/o_*_flush       pipeline register controls (combinational)
//   o_exmem_bubble            EX/MEM captures an invalid entry
//   o_redirect_valid/pc       fetch redirect
//   o_busy                    multi-cycle op in progress
//   o_mc_timeout              sticky multi-cycle abort flag
//   o_stall_cnt/o_flush_cnt   saturating performance counters
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MC_TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_ex_valid,
  input  logic             i_ex_memread,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mispredict,
  input  logic [31:0]      i_ex_target,
  input  logic             i_ex_mc_start,
  input  logic             i_ex_mc_done,
  input  logic             i_cnt_clr,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_idex_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic             o_exmem_bubble,
  output logic             o_redirect_valid,
  output logic [31:0]      o_redirect_pc,
  output logic             o_busy,
  output logic             o_mc_timeout,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int unsigned TMR_W = $clog2(MC_TIMEOUT + 1);

  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(MC_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MC_BUSY = 1'b1;

  logic [0:0]       state_q, state_nxt;
  logic [TMR_W-1:0] timer_q, timer_nxt;

  logic load_use;
  logic mp;
  logic stall_inc;
  logic flush_inc;
  logic timeout_set;

  // Hazard terms; x0 is never a real producer so it cannot cause a stall
  assign load_use = i_ex_valid & i_ex_memread & (i_ex_rd != 5'd0) &
                    ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                     (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));
  assign mp       = i_ex_valid & i_ex_mispredict;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt        = state_q;
    timer_nxt        = timer_q;
    o_pc_stall       = 1'b0;
    o_ifid_stall     = 1'b0;
    o_idex_stall     = 1'b0;
    o_ifid_flush     = 1'b0;
    o_idex_flush     = 1'b0;
    o_exmem_bubble   = 1'b0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = 32'd0;
    stall_inc        = 1'b0;
    flush_inc        = 1'b0;
    timeout_set      = 1'b0;

    if (i_reset_n) begin
      case (state_q)
        ST_RUN: begin
          timer_nxt = '0;
          if (mp) begin
            o_redirect_valid = 1'b1;
            o_redirect_pc    = i_ex_target;
            o_ifid_flush     = 1'b1;
            o_idex_flush     = 1'b1;
            flush_inc        = 1'b1;
          end else if (i_ex_valid & i_ex_mc_start & !i_ex_mc_done) begin
            // Freeze the front of the pipe; EX/MEM sees bubbles until done
            o_pc_stall     = 1'b1;
            o_ifid_stall   = 1'b1;
            o_idex_stall   = 1'b1;
            o_exmem_bubble = 1'b1;
            stall_inc      = 1'b1;
            state_nxt      = ST_MC_BUSY;
            timer_nxt      = TMR_W'(1);
          end else if (load_use) begin
            // Hold the consumer in ID and inject one bubble into EX
            o_pc_stall   = 1'b1;
            o_ifid_stall = 1'b1;
            o_idex_flush = 1'b1;
            stall_inc    = 1'b1;
          end
        end

        ST_MC_BUSY: begin
          if (i_ex_mc_done) begin
            // Release so EX/MEM captures the result this cycle
            state_nxt = ST_RUN;
            timer_nxt = '0;
          end else if (timer_q == TMR_LIMIT) begin
            // Drop the op: kill ID/EX and let EX/MEM take a bubble
            o_idex_flush   = 1'b1;
            o_exmem_bubble = 1'b1;
            timeout_set    = 1'b1;
            state_nxt      = ST_RUN;
            timer_nxt      = '0;
          end else begin
            o_pc_stall     = 1'b1;
            o_ifid_stall   = 1'b1;
            o_idex_stall   = 1'b1;
            o_exmem_bubble = 1'b1;
            stall_inc      = 1'b1;
            timer_nxt      = timer_q + TMR_W'(1);
          end
        end

        default: begin
          state_nxt = ST_RUN;
          timer_nxt = '0;
        end
      endcase
    end
  end

  assign o_busy = i_reset_n & (state_q == ST_MC_BUSY);

  // Timer, sticky timeout flag and saturating counters
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      timer_q      <= '0;
      o_mc_timeout <= 1'b0;
      o_stall_cnt  <= '0;
      o_flush_cnt  <= '0;
    end else begin
      timer_q <= timer_nxt;
      if (i_cnt_clr) begin
        o_mc_timeout <= 1'b0;
        o_stall_cnt  <= '0;
        o_flush_cnt  <= '0;
      end else begin
        if (timeout_set) begin
          o_mc_timeout <= 1'b1;
        end
        if (stall_inc && (o_stall_cnt != CNT_MAX)) begin
          o_stall_cnt <= o_stall_cnt + CNT_W'(1);
        end
        if (flush_inc && (o_flush_cnt != CNT_MAX)) begin
          o_flush_cnt <= o_flush_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
